uart_tx_fifo_mmio: RTL and testbench

Memory-mapped UART transmit peripheral with a parametrised TX FIFO, runtime-programmable baud divisor, status/control registers and a transmit-done interrupt. It replaces the single-entry UART MMIO front end plus external serializer pairing on the CPU system bus. The CPU can queue up to FIFO_DEPTH characters without stalling, and `stall_o` holds the PC only when the FIFO is full.

---
 rtl/uart_tx_fifo_mmio.sv | 207 ++++++++++++++++++++
 tb/tb_uart_tx_fifo_mmio.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_mmio.sv
// Memory-mapped UART transmitter with a TX FIFO, programmable baud divisor and a done interrupt.
// Optional parity bit (CTRL bit3 selects odd) is built when UART_PARITY_EN is defined.
module uart_tx_fifo_mmio #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_wen,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        stall_o,
    output logic        tx_pin,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / BAUD_RATE - 1);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
`ifdef UART_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]          count_reg;
    logic [15:0]          div_reg, div_lat_reg, cnt_reg;
    logic                 tx_en_reg, irq_en_reg, par_odd_reg;
    state_t               state_reg;
    logic [3:0]           bit_idx_reg;
    logic [DATA_BITS-1:0] shreg_reg;
    logic                 par_bit_reg, tx_pin_reg, irq_reg;

    logic full, empty, wr_txdata, wr_div, wr_ctrl, flush, push, pop, bit_end;
    logic unused_wdata;

    assign full      = (count_reg == FULL_CNT);
    assign empty     = (count_reg == '0);
    assign wr_txdata = bus_wen && (bus_addr == 4'h0);
    assign wr_div    = bus_wen && (bus_addr == 4'h8);
    assign wr_ctrl   = bus_wen && (bus_addr == 4'hC);
    assign flush     = wr_ctrl && bus_wdata[2];
    assign push      = wr_txdata && !full && !flush;
    assign pop       = (state_reg == S_IDLE) && !empty && tx_en_reg;
    assign bit_end   = (cnt_reg == div_lat_reg);
    assign stall_o   = wr_txdata && full;
    assign tx_pin    = tx_pin_reg;
    assign irq_o     = irq_reg;
    assign unused_wdata = ^bus_wdata[31:16];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= bus_wdata[DATA_BITS-1:0];
    end

    // Flush only rewinds the pointers; a frame already popped keeps going.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg     <= DIV_RST;
            tx_en_reg   <= 1'b1;
            irq_en_reg  <= 1'b0;
            par_odd_reg <= 1'b0;
        end else begin
            if (wr_div)
                div_reg <= (bus_wdata[15:0] == 16'd0) ? 16'd1 : bus_wdata[15:0];
            if (wr_ctrl) begin
                tx_en_reg  <= bus_wdata[0];
                irq_en_reg <= bus_wdata[1];
`ifdef UART_PARITY_EN
                par_odd_reg <= bus_wdata[3];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            div_lat_reg <= DIV_RST;
            bit_idx_reg <= '0;
            shreg_reg   <= '0;
            par_bit_reg <= 1'b0;
            tx_pin_reg  <= 1'b1;
            irq_reg     <= 1'b0;
        end else begin
            irq_reg <= irq_en_reg && empty && (state_reg == S_IDLE);
            case (state_reg)
                S_IDLE: begin
                    if (pop) begin
                        shreg_reg   <= mem[rd_ptr_reg];
                        par_bit_reg <= (^mem[rd_ptr_reg]) ^ par_odd_reg;
                        div_lat_reg <= div_reg;
                        cnt_reg     <= '0;
                        tx_pin_reg  <= 1'b0;
                        state_reg   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        tx_pin_reg  <= shreg_reg[0];
                        shreg_reg   <= shreg_reg >> 1;
                        state_reg   <= S_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_reg <= '0;
                        if (bit_idx_reg == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            tx_pin_reg <= par_bit_reg;
                            state_reg  <= S_PARITY;
`else
                            tx_pin_reg <= 1'b1;
                            state_reg  <= S_STOP;
`endif
                        end else begin
                            tx_pin_reg  <= shreg_reg[0];
                            shreg_reg   <= shreg_reg >> 1;
                            bit_idx_reg <= bit_idx_reg + 4'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        cnt_reg    <= '0;
                        tx_pin_reg <= 1'b1;
                        state_reg  <= S_STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: begin
                    tx_pin_reg <= 1'b1;
                    state_reg  <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus_rdata = '0;
        case (bus_addr)
            4'h4: begin
                bus_rdata[0]    = full;
                bus_rdata[1]    = empty;
                bus_rdata[2]    = (state_reg != S_IDLE);
                bus_rdata[16:8] = 9'(count_reg);
            end
            4'h8: bus_rdata[15:0] = div_reg;
            4'hC: begin
                bus_rdata[0] = tx_en_reg;
                bus_rdata[1] = irq_en_reg;
`ifdef UART_PARITY_EN
                bus_rdata[3] = par_odd_reg;
`endif
            end
            default: bus_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo_mmio.sv
// Directed bench for uart_tx_fifo_mmio: register access, framing, FIFO stall, flush, irq, reset.
module tb_uart_tx_fifo_mmio;
    localparam int DATA_BITS = 8;
    localparam int BIT_CYC   = 4;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_wen = 1'b0;
    logic [3:0]  bus_addr = 4'h0;
    logic [31:0] bus_wdata = 32'h0;
    logic [31:0] bus_rdata;
    logic        stall_o, tx_pin, irq_o;
    logic        par_odd_tb = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    uart_tx_fifo_mmio #(
        .CLK_FREQ(50000000), .BAUD_RATE(115200), .FIFO_DEPTH(16), .DATA_BITS(DATA_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus_wen(bus_wen), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .stall_o(stall_o),
        .tx_pin(tx_pin), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus_wen = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge clk); #1;
        bus_wen = 1'b0; bus_wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus_addr = a;
        #1;
        d = bus_rdata;
    endtask

    // Holds the store while stall_o is high, like the CPU retrying the same write.
    task automatic push(input logic [7:0] b, output int stall_cycles);
        bus_wen = 1'b1; bus_addr = 4'h0; bus_wdata = {24'h0, b};
        stall_cycles = 0;
        #1;
        while (stall_o && stall_cycles < 400) begin
            stall_cycles++;
            @(posedge clk); #1;
        end
        if (stall_o) check("push_stall_bound", 32'(stall_o), 32'h0);
        @(posedge clk); #1;
        bus_wen = 1'b0; bus_wdata = 32'h0;
    endtask

    task automatic capture_check(input string tag, input logic [7:0] exp);
        logic [FRAME_BITS-1:0]         ev;
        logic [FRAME_BITS*BIT_CYC-1:0] s;
        logic [7:0] got;
        int w, bad;
        ev = '0;
        ev[0] = 1'b0;
        ev[DATA_BITS:1] = exp;
`ifdef UART_PARITY_EN
        ev[DATA_BITS+1] = (^exp) ^ par_odd_tb;
`endif
        ev[FRAME_BITS-1] = 1'b1;
        w = 0;
        while (tx_pin !== 1'b0 && w < 300) begin
            tick(1);
            w++;
        end
        if (tx_pin !== 1'b0) begin
            check({tag, "_start_seen"}, 32'(tx_pin), 32'h0);
            return;
        end
        for (int i = 0; i < FRAME_BITS*BIT_CYC; i++) begin
            s[i] = tx_pin;
            tick(1);
        end
        bad = 0;
        for (int i = 0; i < FRAME_BITS*BIT_CYC; i++)
            if (s[i] !== ev[i/BIT_CYC]) bad++;
        for (int k = 0; k < DATA_BITS; k++)
            got[k] = s[(k+1)*BIT_CYC + 2];
        check({tag, "_data"}, 32'(got), 32'(exp));
        check({tag, "_bad_samples"}, 32'(bad), 32'h0);
`ifdef UART_PARITY_EN
        check({tag, "_parity"}, 32'(s[(DATA_BITS+1)*BIT_CYC + 2]), 32'(ev[DATA_BITS+1]));
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int sc, cnt;

        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_tx_pin", 32'(tx_pin), 32'h1);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        bus_read(4'h4, rd); check("rst_status", rd, 32'h2);
        bus_read(4'h8, rd); check("rst_div", rd, 32'd433);
        bus_read(4'hC, rd); check("rst_ctrl", rd, 32'h1);
        bus_read(4'h0, rd); check("txdata_reads_0", rd, 32'h0);

        bus_write(4'h8, 32'h0);
        bus_read(4'h8, rd); check("div_clamp", rd, 32'h1);
        bus_write(4'h8, 32'h3);
        bus_read(4'h8, rd); check("div_write", rd, 32'h3);
`ifndef UART_PARITY_EN
        bus_write(4'hC, 32'h9);
        bus_read(4'hC, rd); check("ctrl_bit3_ignored", rd, 32'h1);
        bus_write(4'hC, 32'h1);
`endif

        // Single frame 0x55 and its first-transaction latency
        push(8'h55, sc);
        check("t1_tx_before_pop", 32'(tx_pin), 32'h1);
        bus_read(4'h4, rd); check("t1_status_queued", rd, 32'h100);
        tick(1);
        check("t1_tx_start", 32'(tx_pin), 32'h0);
        bus_read(4'h4, rd); check("t1_status_busy", rd, 32'h6);
        capture_check("t1_0x55", 8'h55);
        bus_read(4'h4, rd); check("t1_status_done", rd, 32'h2);

        // FIFO fill behind an in-flight frame; 17th write must stall
        push(8'hC3, sc);
        fork
            begin
                capture_check("t2_inflight", 8'hC3);
                for (int j = 0; j < 17; j++)
                    capture_check($sformatf("t2_byte%0d", j), 8'(j*37 + 17));
            end
            begin
                int tot;
                tot = 0;
                tick(3);
                for (int j = 0; j < 16; j++) begin
                    push(8'(j*37 + 17), sc);
                    tot += sc;
                end
                check("t2_no_stall_first16", 32'(tot), 32'h0);
                bus_read(4'h4, rd); check("t2_status_full", rd, 32'h1005);
                push(8'(16*37 + 17), sc);
                check("t2_17th_stalled", 32'(sc > 0), 32'h1);
                bus_read(4'h4, rd); check("t2_status_refull", rd, 32'h1005);
            end
        join
        bus_read(4'h4, rd); check("t2_status_drained", rd, 32'h2);

        // tx_en cleared mid-frame
        push(8'hA5, sc);
        fork
            capture_check("t3_0xA5", 8'hA5);
            begin
                tick(10);
                bus_write(4'hC, 32'h0);
                push(8'h3C, sc);
            end
        join
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx_pin !== 1'b1) cnt++;
            tick(1);
        end
        check("t3_held_idle_low_cycles", 32'(cnt), 32'h0);
        bus_read(4'h4, rd); check("t3_status_held", rd, 32'h100);
        bus_write(4'hC, 32'h1);
        capture_check("t3_0x3C", 8'h3C);

        // Interrupt timing
        bus_write(4'hC, 32'h3);
        tick(1);
        check("t4_irq_idle", 32'(irq_o), 32'h1);
        push(8'h96, sc);
        tick(1);
        check("t4_irq_drop", 32'(irq_o), 32'h0);
        cnt = 0;
        for (int i = 0; i < 39; i++) begin
            tick(1);
            if (irq_o !== 1'b0) cnt++;
        end
        check("t4_irq_high_in_frame", 32'(cnt), 32'h0);
        tick(1);
        check("t4_irq_on_idle_edge", 32'(irq_o), 32'h0);
        tick(1);
        check("t4_irq_after_idle", 32'(irq_o), 32'h1);

        // Flush with three bytes queued behind the current frame
        for (int j = 1; j <= 4; j++) push(8'(j), sc);
        bus_read(4'h4, rd); check("t4_status_3q", rd, 32'h304);
        bus_write(4'hC, 32'h7);
        bus_read(4'h4, rd); check("t4_status_flushed", rd, 32'h6);
        bus_read(4'hC, rd); check("t4_ctrl_flush_reads0", rd, 32'h3);
        cnt = 0;
        bus_read(4'h4, rd);
        while (rd[2] && cnt < 100) begin
            tick(1);
            cnt++;
            bus_read(4'h4, rd);
        end
        check("t4_frame_finished", 32'(rd[2]), 32'h0);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx_pin !== 1'b1) cnt++;
            tick(1);
        end
        check("t4_no_frame_after_flush", 32'(cnt), 32'h0);
        check("t4_irq_after_flush", 32'(irq_o), 32'h1);

        // Asynchronous reset in the middle of DATA
        bus_write(4'hC, 32'h1);
        push(8'h00, sc);
        tick(12);
        check("t5_tx_in_data", 32'(tx_pin), 32'h0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx_pin", 32'(tx_pin), 32'h1);
        bus_read(4'h4, rd); check("t5_rst_status", rd, 32'h2);
        bus_read(4'h8, rd); check("t5_rst_div", rd, 32'd433);
        bus_read(4'hC, rd); check("t5_rst_ctrl", rd, 32'h1);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("t5_post_rst_tx", 32'(tx_pin), 32'h1);
        bus_read(4'h4, rd); check("t5_post_rst_status", rd, 32'h2);

`ifdef UART_PARITY_EN
        bus_write(4'h8, 32'h3);
        par_odd_tb = 1'b0;
        bus_write(4'hC, 32'h1);
        push(8'h07, sc);
        capture_check("t6_even_0x07", 8'h07);
        bus_read(4'h4, rd); check("t6_len44_done", rd, 32'h2);
        par_odd_tb = 1'b1;
        bus_write(4'hC, 32'h9);
        bus_read(4'hC, rd); check("t6_ctrl_par_odd", rd, 32'h9);
        push(8'h07, sc);
        capture_check("t6_odd_0x07", 8'h07);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
